pulse_modulation: RTL and testbench
===================================

Name:
pulse_modulation

Overview:
- Per-motor pulse-width generator for an RC-style motor-controller servo signal.
- Converts a 5-bit command (direction + 4-bit magnitude) into a 22-bit pulse-width count for the current refresh frame.
- Power is set by frame dithering across a 24-frame cycle: some frames get the full-power width, the rest get the neutral width.
- The parent PWM block supplies the frame index on `State` (0..23, advancing once per 11 ms frame) and compares its frame counter against `Pulse`. The same block is instantiated once per motor.

Parameters:
- NEUTRAL_W, 109090, pulse count for the stop/neutral width (1.5 ms at the 72.727 MHz system clock).
- FULL_OFS, 36363, count added or subtracted from NEUTRAL_W in a full-power frame (0.5 ms).
- INVERT_DIR, 0, when 1 the meaning of the direction bit is swapped (used for a mirror-mounted motor).

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- ModInfo  input  5  command; bit 4 = direction (1 forward), bits 3:0 = magnitude m (0..15).
- State  input  5  frame index within the 24-frame dither cycle; legal range 0..23.
- Pulse  output  22  registered pulse-width count for the current frame.

Behaviour:
- Reset (RST high at a rising edge) sets:
  - Pulse = NEUTRAL_W
  - latched command = 0
  - previous-State register = 31
- RST takes priority over all other updates. Reset mid-cycle immediately forces neutral and discards the latched command.
- Command latch:
  - An "entry" occurs on a cycle where State == 0 and previous-State != 0.
  - On entry, latched command <= ModInfo.
  - previous-State <= State every cycle.
  - ModInfo changes outside an entry have no effect until the next entry. This prevents jitter inside a dither cycle.
  - Because previous-State resets to 31, State == 0 on the first cycle after reset counts as an entry.
- Effective command = ModInfo on an entry cycle, otherwise the latched command.
- Active-frame count N(m), using m from the effective command: N = floor((m*24+7)/15).

  | m | 0 | 1 | 2 | 3 | 4 | 5 | 6 | 7 | 8 | 9 | 10 | 11 | 12 | 13 | 14 | 15 |
  |---|---|---|---|---|---|---|---|---|---|---|----|----|----|----|----|----|
  | N | 0 | 2 | 3 | 5 | 6 | 8 | 10 | 11 | 13 | 14 | 16 | 18 | 19 | 21 | 22 | 24 |

  Implement N as a 16-entry constant table; no runtime divider.
- A frame is active if State < N. State >= 24 is never active.
- Direction:
  - fwd = ModInfo bit 4 XOR INVERT_DIR.
  - Active with fwd = 1: Pulse next = NEUTRAL_W + FULL_OFS.
  - Active with fwd = 0: Pulse next = NEUTRAL_W - FULL_OFS.
  - Inactive frame: Pulse next = NEUTRAL_W.
- Magnitude 0 yields NEUTRAL_W in all frames regardless of direction.
- Arithmetic is done at 22 bits, unsigned. Parameters must satisfy FULL_OFS <= NEUTRAL_W and NEUTRAL_W + FULL_OFS < 2^22.
- Latency:
  - Pulse reflects State one clock after State changes.
  - A command captured on an entry affects Pulse on the next clock, i.e. the same edge that registers frame 0's width.
- Pulse is held constant while State and the latched command are constant.
- No handshake: State is assumed to change at most once per frame, and the block tolerates any change rate.

Test Plan:
- Reset: assert RST for 2 cycles with ModInfo = 5'b11111 -> Pulse = 109090 throughout and on the first cycle after release unless State = 0 triggers an entry.
- Full forward: ModInfo = 5'b11111, sweep State 0..23 -> Pulse = 145453 in all 24 frames, each update one clock after its State change.
- Partial reverse: ModInfo = 5'b00101 (m = 5, N = 8), sweep State 0..23 -> Pulse = 72727 for State 0..7 and 109090 for State 8..23.
- Latch hold: start a cycle with ModInfo = 5'b10010 (N = 3), change ModInfo to 5'b11111 at State = 10 -> Pulse stays 109090 for frames 10..23; the next State = 0 entry gives 145453 for all frames of the following cycle.
- INVERT_DIR = 1 instance: ModInfo = 5'b11111 -> Pulse = 72727 in every frame. Magnitude 0 with either direction bit -> 109090 in every frame.
- Out-of-range State: State = 24..31 with ModInfo = 5'b11111 -> Pulse = 109090. State 31 -> 0 transition counts as an entry and latches ModInfo.

Source files
------------

// File: rtl/pulse_modulation.sv
// Per-motor servo pulse-width generator: turns a direction/magnitude command
// into a frame-dithered pulse count over a 24-frame cycle.
module pulse_modulation #(
    parameter int unsigned NEUTRAL_W  = 109090,
    parameter int unsigned FULL_OFS   = 36363,
    parameter bit          INVERT_DIR = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  ModInfo,
    input  logic [4:0]  State,
    output logic [21:0] Pulse
);

    localparam logic [21:0] NEUTRAL = 22'(NEUTRAL_W);
    localparam logic [21:0] FWD_W   = 22'(NEUTRAL_W + FULL_OFS);
    localparam logic [21:0] REV_W   = 22'(NEUTRAL_W - FULL_OFS);

    logic [4:0]  latched_cmd;
    logic [4:0]  prev_state;
    logic        entry;
    logic [4:0]  cmd;
    logic [4:0]  active_n;
    logic        active;
    logic        fwd;
    logic [21:0] next_pulse;

    // Active frames per 24-frame cycle: floor((m*24+7)/15)
    function automatic logic [4:0] frames_for(input logic [3:0] m);
        logic [4:0] n;
        case (m)
            4'd0:    n = 5'd0;
            4'd1:    n = 5'd2;
            4'd2:    n = 5'd3;
            4'd3:    n = 5'd5;
            4'd4:    n = 5'd6;
            4'd5:    n = 5'd8;
            4'd6:    n = 5'd10;
            4'd7:    n = 5'd11;
            4'd8:    n = 5'd13;
            4'd9:    n = 5'd14;
            4'd10:   n = 5'd16;
            4'd11:   n = 5'd18;
            4'd12:   n = 5'd19;
            4'd13:   n = 5'd21;
            4'd14:   n = 5'd22;
            default: n = 5'd24;
        endcase
        return n;
    endfunction

    always_comb begin
        entry    = (State == 5'd0) && (prev_state != 5'd0);
        cmd      = entry ? ModInfo : latched_cmd;
        active_n = frames_for(cmd[3:0]);
        // N never exceeds 24, so States 24..31 always fall through as inactive
        active   = State < active_n;
        fwd      = cmd[4] ^ INVERT_DIR;
        if (!active)
            next_pulse = NEUTRAL;
        else if (fwd)
            next_pulse = FWD_W;
        else
            next_pulse = REV_W;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Pulse       <= NEUTRAL;
            latched_cmd <= 5'd0;
            prev_state  <= 5'd31;
        end else begin
            Pulse      <= next_pulse;
            prev_state <= State;
            if (entry)
                latched_cmd <= ModInfo;
        end
    end

endmodule

// File: tb/tb_pulse_modulation.sv
// Randomised and directed bench for pulse_modulation, one normal and one
// direction-inverted instance against a frame-cycle reference model.
module tb_pulse_modulation;

    localparam int NEUTRAL = 109090;
    localparam int OFS     = 36363;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mod_info;
    logic [4:0]  state;
    logic [21:0] pulse_n;
    logic [21:0] pulse_i;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state: command held for the current cycle, last State seen
    logic [4:0] m_lat;
    logic [4:0] m_prev;
    int         e0;
    int         e1;

    always #5 clk = ~clk;

    pulse_modulation #(.INVERT_DIR(1'b0)) dut_n (
        .CLK(clk), .RST(rst), .ModInfo(mod_info), .State(state), .Pulse(pulse_n)
    );

    pulse_modulation #(.INVERT_DIR(1'b1)) dut_i (
        .CLK(clk), .RST(rst), .ModInfo(mod_info), .State(state), .Pulse(pulse_i)
    );

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    function automatic int model_width(input logic [4:0] c, input int st, input bit inv);
        int m;
        int n;
        m = int'(c[3:0]);
        n = (m * 24 + 7) / 15;
        if (st >= n)
            return NEUTRAL;
        return (c[4] ^ inv) ? NEUTRAL + OFS : NEUTRAL - OFS;
    endfunction

    task automatic cycle(input bit r, input logic [4:0] mi, input logic [4:0] st,
                         input string tag);
        rst      = r;
        mod_info = mi;
        state    = st;
        @(posedge clk);
        if (r) begin
            m_lat  = 5'd0;
            m_prev = 5'd31;
            e0     = NEUTRAL;
            e1     = NEUTRAL;
        end else begin
            if (st == 5'd0 && m_prev != 5'd0)
                m_lat = mi;
            e0     = model_width(m_lat, int'(st), 1'b0);
            e1     = model_width(m_lat, int'(st), 1'b1);
            m_prev = st;
        end
        #1;
        check({tag, "/norm"}, int'(pulse_n), e0);
        check({tag, "/inv"}, int'(pulse_i), e1);
    endtask

    // one full dither cycle with fixed command; want < 0 skips the constant check
    task automatic sweep(input logic [4:0] mi, input string tag,
                         input int want0, input int want1);
        for (int s = 0; s < 24; s++) begin
            cycle(1'b0, mi, 5'(s), tag);
            if (want0 >= 0)
                check({tag, "/const_norm"}, int'(pulse_n), want0);
            if (want1 >= 0)
                check({tag, "/const_inv"}, int'(pulse_i), want1);
        end
    endtask

    initial begin
        int cur;
        logic [4:0] mi;
        bit r;

        // reset held with a full-forward command pending
        cycle(1'b1, 5'b11111, 5'd5, "reset");
        check("reset_const", int'(pulse_n), NEUTRAL);
        cycle(1'b1, 5'b11111, 5'd5, "reset");
        check("reset_const", int'(pulse_n), NEUTRAL);
        cycle(1'b0, 5'b11111, 5'd5, "post_reset");
        check("post_reset_const", int'(pulse_n), NEUTRAL);

        sweep(5'b11111, "full_fwd", NEUTRAL + OFS, NEUTRAL - OFS);
        sweep(5'b00101, "part_rev", -1, -1);
        check("part_rev_last", int'(pulse_n), NEUTRAL);

        // command latched at State 0 must ignore a change mid-cycle
        for (int s = 0; s < 10; s++) begin
            cycle(1'b0, 5'b10010, 5'(s), "latch_a");
            check("latch_a_const", int'(pulse_n), (s < 3) ? NEUTRAL + OFS : NEUTRAL);
        end
        for (int s = 10; s < 24; s++) begin
            cycle(1'b0, 5'b11111, 5'(s), "latch_b");
            check("latch_b_const", int'(pulse_n), NEUTRAL);
        end
        sweep(5'b11111, "latch_next", NEUTRAL + OFS, NEUTRAL - OFS);

        sweep(5'b10000, "mag0_fwd", NEUTRAL, NEUTRAL);
        sweep(5'b00000, "mag0_rev", NEUTRAL, NEUTRAL);

        // partial cycle, then out-of-range frames with full command
        sweep(5'b11111, "pre_oor", -1, -1);
        for (int s = 24; s < 32; s++) begin
            cycle(1'b0, 5'b11111, 5'(s), "oor");
            check("oor_const", int'(pulse_n), NEUTRAL);
        end
        cycle(1'b0, 5'b00111, 5'd0, "oor_entry");
        check("oor_entry_const", int'(pulse_n), NEUTRAL - OFS);

        // reset mid-cycle forces neutral and drops the command
        cycle(1'b0, 5'b00111, 5'd1, "mid");
        cycle(1'b1, 5'b00111, 5'd2, "mid_rst");
        check("mid_rst_const", int'(pulse_n), NEUTRAL);
        cycle(1'b0, 5'b11111, 5'd3, "after_rst");
        check("after_rst_const", int'(pulse_n), NEUTRAL);

        // random frame progression, holds, jumps, command changes and resets
        cur = 0;
        mi  = 5'($urandom);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom % 50) == 0;
            if (($urandom % 6) == 0)
                mi = 5'($urandom);
            if (($urandom % 30) == 0)
                cur = int'($urandom % 32);
            else if (($urandom % 4) != 0)
                cur = (cur + 1) % 24;
            cycle(r, mi, 5'(cur), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
